// File: rtl/multi_debouncer_pkg.sv
// multi_debouncer_pkg: debounce FSM state type and synchroniser depth shared by the debouncer files
package multi_debouncer_pkg;
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/db_channel.sv
// db_channel: one button's synchroniser, debounce FSM and press/release/long-press ticks
// Macro LONG_PRESS_EN builds the long-press counter; without it long_tick is tied low.
module db_channel
  import multi_debouncer_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int LP_W  = 26
) (
  input  logic clk_50Mhz,
  input  logic rst_n,
  input  logic btn,
  output logic db_level,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick
);
  logic [SYNC_DEPTH-1:0] sync;
  logic s;
  db_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  assign s = sync[SYNC_DEPTH-1];
  always_ff @(posedge clk_50Mhz) begin
    if (!rst_n) begin
      sync         <= '0;
      state        <= ZERO;
      cnt          <= '0;
      db_level     <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
    end else begin
      sync         <= {sync[SYNC_DEPTH-2:0], btn};
      state        <= state_nx;
      cnt          <= cnt_nx;
      db_level     <= state_nx == ONE || state_nx == WAIT0;
      press_tick   <= state == WAIT1 && state_nx == ONE;
      release_tick <= state == WAIT0 && state_nx == ZERO;
    end
  end
  // Counter is reloaded on entering a wait state and parks at zero, so it never wraps
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ZERO:  if (s) begin state_nx = WAIT1; cnt_nx = '1; end
      WAIT1: if (!s) state_nx = ZERO; else if (cnt == '0) state_nx = ONE; else cnt_nx = cnt - 1'b1;
      ONE:   if (!s) begin state_nx = WAIT0; cnt_nx = '1; end
      default: if (s) state_nx = ONE; else if (cnt == '0) state_nx = ZERO; else cnt_nx = cnt - 1'b1;
    endcase
  end
`ifdef LONG_PRESS_EN
  logic [LP_W-1:0] lp;
  always_ff @(posedge clk_50Mhz) begin
    if (!rst_n) begin
      lp        <= '0;
      long_tick <= 1'b0;
    end else begin
      lp        <= state == ZERO ? '0 : (state == ONE && lp != '1) ? lp + 1'b1 : lp;
      long_tick <= state == ONE && lp == {{(LP_W-1){1'b1}}, 1'b0};
    end
  end
`else
  assign long_tick = 1'b0;
`endif
endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: CH independent debounced buttons plus an any-pressed summary level
// Macro LONG_PRESS_EN enables per-channel long-press ticks.
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CNT_W = 20,
  parameter int LP_W  = 26
) (
  input  logic          clk_50Mhz,
  input  logic          rst_n,
  input  logic [CH-1:0] btn,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] press_tick,
  output logic [CH-1:0] release_tick,
  output logic [CH-1:0] long_tick,
  output logic          any_level
);
  for (genvar c = 0; c < CH; c++) begin : g_ch
    db_channel #(.CNT_W(CNT_W), .LP_W(LP_W)) u_ch (
      .clk_50Mhz    (clk_50Mhz),
      .rst_n        (rst_n),
      .btn          (btn[c]),
      .db_level     (db_level[c]),
      .press_tick   (press_tick[c]),
      .release_tick (release_tick[c]),
      .long_tick    (long_tick[c])
    );
  end
  assign any_level = |db_level;
endmodule
